// File: rtl/decode_pkg.sv
// decode_pkg: opcode map, class and FIFO-state enums, and instruction field positions
package decode_pkg;
  localparam logic [5:0] OP_R0   = 6'b000000;
  localparam logic [5:0] OP_R1   = 6'b001000;
  localparam logic [5:0] OP_BR0  = 6'b000001;
  localparam logic [5:0] OP_BR1  = 6'b001001;
  localparam logic [5:0] OP_LW   = 6'b000010;
  localparam logic [5:0] OP_SW   = 6'b000011;
  localparam logic [5:0] OP_J    = 6'b000100;
  localparam logic [5:0] OP_SLTI = 6'b000110;
  localparam logic [5:0] OP_ORI  = 6'b000111;
  localparam logic [5:0] OP_ADDI = 6'b001010;
  localparam logic [5:0] OP_LUI  = 6'b101010;
  localparam int OP_HI = 31, OP_LO = 26;
  localparam int RS_HI = 25, RS_LO = 21;
  localparam int RT_HI = 20, RT_LO = 16;
  localparam int RD_HI = 15, RD_LO = 11;
  localparam int SH_HI = 10, SH_LO = 6;
  localparam int FT_HI = 5, FT_LO = 0;
  localparam int ALU_HI = 3, ALU_LO = 2;
  localparam int IMM_HI = 15, IMM_LO = 0;
  localparam int JT_HI = 25, JT_LO = 0;
  typedef enum logic [2:0] {CLS_R, CLS_BR, CLS_LW, CLS_SW, CLS_J, CLS_LUI, CLS_IMM, CLS_ILL} cls_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} fifo_state_t;
  function automatic cls_t opcode_cls(input logic [5:0] o);
    return (o == OP_R0 || o == OP_R1) ? CLS_R :
           (o == OP_BR0 || o == OP_BR1) ? CLS_BR :
           (o == OP_LW) ? CLS_LW :
           (o == OP_SW) ? CLS_SW :
           (o == OP_J) ? CLS_J :
           (o == OP_SLTI || o == OP_ORI || o == OP_ADDI) ? CLS_IMM :
           (o == OP_LUI) ? CLS_LUI : CLS_ILL;
  endfunction
endpackage

// File: rtl/decode_skid_buf.sv
// decode_skid_buf: 2-entry FIFO holding decoded entries between decode and the consumer
// Ports: clk, rst (async, active-high), flush (sync discard), in_valid/in_ready/in_data upstream,
// out_valid/out_ready/out_data downstream; out_data is 0 while empty.
module decode_skid_buf import decode_pkg::*; #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  fifo_state_t state, state_n;
  logic wr_ptr, rd_ptr;
  logic [W-1:0] mem [2];
  logic push, pop;
  assign in_ready  = state != FULL;
  assign out_valid = state != EMPTY;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  always_comb begin
    state_n = state;
    case (state)
      EMPTY:   state_n = push ? ONE : EMPTY;
      ONE:     state_n = (push & !pop) ? FULL : (pop & !push) ? EMPTY : ONE;
      FULL:    state_n = pop ? ONE : FULL;
      default: state_n = EMPTY;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush) begin
      state  <= EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      state  <= state_n;
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
    end
  // A word written during a flush is harmless: the pointers return to 0 and the slot is never read.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: combinational instruction decode registered into a 2-entry output FIFO
// Ports: clk, rst (async, active-high), flush; in_valid/in_ready/in_instr/in_pc upstream;
// out_valid/out_ready downstream with decoded fields op, rs, rt, rd, shamt, ftn, aluop,
// imm_ext, jump_addr, lui_val, cls, reg_we, mem_re, mem_we, illegal (all 0 while empty).
// Macro DECODE_ILLEGAL_TRAP_EN: flag unknown opcodes as cls=ILL/illegal=1; otherwise they decode as a NOP.
module instr_decode_stage import decode_pkg::*; #(
  parameter int XLEN         = 32,
  parameter int SIGN_EXT_IMM = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      op,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [4:0]      shamt,
  output logic [5:0]      ftn,
  output logic [1:0]      aluop,
  output logic [XLEN-1:0] imm_ext,
  output logic [XLEN-1:0] jump_addr,
  output logic [XLEN-1:0] lui_val,
  output logic [2:0]      cls,
  output logic            reg_we,
  output logic            mem_re,
  output logic            mem_we,
  output logic            illegal
);
  typedef struct packed {
    logic [5:0]      op;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [5:0]      ftn;
    logic [1:0]      aluop;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] jump_addr;
    logic [XLEN-1:0] lui_val;
    cls_t            cls;
    logic            reg_we;
    logic            mem_re;
    logic            mem_we;
    logic            illegal;
  } dec_t;
  dec_t d, q;
  logic [5:0] opc;
  logic [15:0] imm;
  cls_t c;
  logic is_r, is_br, is_lw, is_sw, is_j, is_lui, is_imm, is_ill;
  logic use_rs, use_imm, zext;
  logic unused_pc;
  assign opc       = in_instr[OP_HI:OP_LO];
  assign imm       = in_instr[IMM_HI:IMM_LO];
  assign c         = opcode_cls(opc);
  assign is_r      = c == CLS_R;
  assign is_br     = c == CLS_BR;
  assign is_lw     = c == CLS_LW;
  assign is_sw     = c == CLS_SW;
  assign is_j      = c == CLS_J;
  assign is_lui    = c == CLS_LUI;
  assign is_imm    = c == CLS_IMM;
  assign is_ill    = c == CLS_ILL;
  assign use_rs    = is_r | is_br | is_lw | is_sw | is_imm;
  assign use_imm   = is_br | is_lw | is_sw | is_imm;
  assign zext      = (SIGN_EXT_IMM == 0) || (opc == OP_ORI);
  assign unused_pc = ^in_pc[27:0];
  // Unknown opcodes fall through every class predicate, so all fields and enables are already 0.
  always_comb begin
    d           = '0;
    d.rs        = use_rs ? in_instr[RS_HI:RS_LO] : '0;
    d.rt        = (use_rs | is_lui) ? in_instr[RT_HI:RT_LO] : '0;
    d.rd        = is_r ? in_instr[RD_HI:RD_LO] : '0;
    d.shamt     = is_r ? in_instr[SH_HI:SH_LO] : '0;
    d.ftn       = is_r ? in_instr[FT_HI:FT_LO] : '0;
    d.aluop     = is_r ? in_instr[ALU_HI:ALU_LO] : '0;
    d.imm_ext   = !use_imm ? '0 : zext ? XLEN'(imm) : XLEN'($signed(imm));
    d.jump_addr = is_j ? {in_pc[XLEN-1:28], in_instr[JT_HI:JT_LO], 2'b00} : '0;
    d.lui_val   = is_lui ? XLEN'($signed({imm, 16'b0})) : '0;
    d.reg_we    = is_r | is_lw | is_imm | is_lui;
    d.mem_re    = is_lw;
    d.mem_we    = is_sw;
`ifdef DECODE_ILLEGAL_TRAP_EN
    d.op        = opc;
    d.cls       = c;
    d.illegal   = is_ill;
`else
    d.op        = is_ill ? '0 : opc;
    d.cls       = is_ill ? CLS_R : c;
    d.illegal   = 1'b0;
`endif
  end
  decode_skid_buf #(.W($bits(dec_t))) u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (q)
  );
  assign op        = q.op;
  assign rs        = q.rs;
  assign rt        = q.rt;
  assign rd        = q.rd;
  assign shamt     = q.shamt;
  assign ftn       = q.ftn;
  assign aluop     = q.aluop;
  assign imm_ext   = q.imm_ext;
  assign jump_addr = q.jump_addr;
  assign lui_val   = q.lui_val;
  assign cls       = q.cls;
  assign reg_we    = q.reg_we;
  assign mem_re    = q.mem_re;
  assign mem_we    = q.mem_we;
  assign illegal   = q.illegal;
endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of imm_ext, jump_addr and in_pc; legal range 32..64.
REQ-002 Parameter SIGN_EXT_IMM, default 1: 1 sign-extends constants, 0 zero-extends them (ori always zero-extends).
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous discard of all buffered entries.
REQ-006 in_valid / in_ready  input / output  1 / 1  upstream handshake.
REQ-007 in_instr  input  32  instruction word.
REQ-008 in_pc  input  XLEN  PC of in_instr.
REQ-009 out_valid / out_ready  output / input  1 / 1  downstream handshake.
REQ-010 op output 6; rs, rt, rd, shamt output 5 each; ftn output 6; aluop output 2.
REQ-011 imm_ext output XLEN; jump_addr output XLEN; lui_val output XLEN.
REQ-012 cls output 3: R, BR, LW, SW, J, LUI, IMM, ILL.
REQ-013 reg_we, mem_re, mem_we, illegal output 1 each.

Function
REQ-014 Opcode map: 000000/001000 R; 000001/001001 BR; 000010 LW; 000011 SW; 000100 J; 000110 slti, 000111 ori, 001010 addi (all IMM); 101010 LUI; anything else ILL.
REQ-015 Decode is combinational on in_instr; the result is registered into a 2-entry FIFO, so latency is 1 cycle from an accepted input to out_valid when the FIFO is empty.
REQ-016 FIFO state: EMPTY, ONE, FULL; push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-017 Transitions: EMPTY push -> ONE; ONE push & !pop -> FULL; ONE pop & !push -> EMPTY; ONE push & pop -> ONE; FULL pop -> ONE.
REQ-018 in_ready = (state != FULL); it never depends combinationally on out_ready.
REQ-019 out_valid = (state != EMPTY); outputs show the head entry and stay stable while out_valid & !out_ready.
REQ-020 Field extraction: rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], ftn=[5:0], aluop=[3:2]; fields unused by the class are driven 0, never X.
REQ-021 imm_ext = [15:0] extended to XLEN per SIGN_EXT_IMM for BR/LW/SW/IMM; 0 otherwise.
REQ-022 jump_addr = {in_pc[XLEN-1:28], instr[25:0], 2'b00} for J; 0 otherwise.
REQ-023 lui_val = {instr[15:0], 16'b0} sign-extended to XLEN for LUI; 0 otherwise.
REQ-024 reg_we = 1 for R, LW, IMM, LUI; mem_re = 1 for LW only; mem_we = 1 for SW only.
REQ-025 flush forces EMPTY at the next edge and overrides a simultaneous push and pop; in_ready stays as computed in that cycle, but the pushed word is dropped.
REQ-026 Pop order is strict FIFO; wrap of the 1-bit read/write pointers is natural modulo 2.

Reset
REQ-027 rst asserted: state=EMPTY, pointers=0, out_valid=0, in_ready=1, all decoded outputs 0; takes effect immediately, including mid-transfer.
REQ-028 After rst deasserts, the first push is accepted on the next rising edge.

Configuration
REQ-029 Macro DECODE_ILLEGAL_TRAP_EN present: ILL opcodes set illegal=1 and cls=ILL, with reg_we/mem_re/mem_we forced 0.
REQ-030 Macro absent: illegal is tied 0, and ILL opcodes are presented as cls=R with all fields 0 and all enables 0 (NOP).

Structure
REQ-031 Package decode_pkg holds the opcode localparams, the cls enum, and the field bit-position constants.
REQ-032 Sub-module decode_skid_buf (2-entry, payload-width parameter) holds the FIFO; decode logic lives in the top module.

Verification
REQ-033 Reset release, then in_instr=0x00430820 (R, rs=2, rt=3, rd=1) with out_ready=1 -> next cycle out_valid=1, cls=R, rd=1, reg_we=1, imm_ext=0.
REQ-034 Hold out_ready=0 and push lw 0x0822FFFC then sw 0x0C22FFFC -> FULL, in_ready=0, imm_ext=0xFFFFFFFC; release out_ready -> lw then sw, two consecutive cycles.
REQ-035 J 0x10000010 with in_pc=0xA0000000 -> jump_addr=0xA0000040, reg_we=0.
REQ-036 flush while FULL with concurrent push -> next cycle out_valid=0, the pushed entry is never output.
REQ-037 Opcode 0x3F with DECODE_ILLEGAL_TRAP_EN -> illegal=1, cls=ILL; without the macro -> illegal=0, all enables 0.
REQ-038 rst asserted while state ONE with out_ready=0 -> out_valid drops asynchronously, in_ready=1.
